// File: rtl/gate_tb_pkg.sv
// Shared definitions for the 2-input gate stimulus/checker: FSM state
// encoding, reference truth tables and the number of input vectors.
package gate_tb_pkg;

  // Number of {a,b} input combinations swept per run.
  localparam int unsigned VEC_COUNT = 4;

  // Truth tables: bit index {a,b} holds the expected gate output.
  localparam logic [3:0] AND_TT  = 4'b1000;
  localparam logic [3:0] OR_TT   = 4'b1110;
  localparam logic [3:0] XOR_TT  = 4'b0110;
  localparam logic [3:0] XNOR_TT = 4'b1001;
  localparam logic [3:0] NAND_TT = 4'b0111;
  localparam logic [3:0] NOR_TT  = 4'b0001;

  // Sweep controller states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_FINISH = 2'd3
  } gate_state_e;

endpackage

// File: rtl/gate_stim_checker_dwell_counter.sv
// Dwell counter: counts up while enabled, clears on request and flags the
// cycle in which the count equals the terminal value.
module dwell_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] tc_value,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  // Count register: clear has priority over increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == tc_value);

endmodule

// File: rtl/gate_stim_checker.sv
// Exhaustive stimulus generator and checker for a 2-input gate. On start it
// drives {a,b} = 00,01,10,11, holding each vector DWELL cycles, samples the
// gate output in the last cycle of each vector and reports mismatches.
//
// Handshake: start is a one-cycle request honoured only while idle; busy is
// high for the whole sweep and done pulses for one cycle at completion, when
// pass/err_count/fail_vec are valid (and held until the next accepted start).
module gate_stim_checker
  import gate_tb_pkg::*;
#(
  parameter int unsigned DWELL     = 10,
  parameter logic [3:0]  EXPECT_TT = XNOR_TT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec,
  output logic [1:0] state_dbg
);

  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_DRIVE  = ST_DRIVE;
  localparam logic [1:0] S_SAMPLE = ST_SAMPLE;
  localparam logic [1:0] S_FINISH = ST_FINISH;

  // DRIVE lasts DWELL-1 cycles, SAMPLE one more: DWELL cycles per vector.
  localparam logic [7:0] DWELL_TC = 8'(DWELL - 2);
  localparam logic [2:0] ERR_MAX  = 3'(VEC_COUNT);

  logic [1:0] state;
  logic [1:0] vec_idx;
  logic [1:0] vec_next;
  logic       dwell_tc;
  logic       miss;

  assign vec_next = vec_idx + 2'd1;

  // y only reaches registers, never an output directly.
  assign miss = (y != EXPECT_TT[{a, b}]);

  dwell_counter #(
    .WIDTH (8)
  ) u_dwell (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (state != S_DRIVE),
    .en       (1'b1),
    .tc_value (DWELL_TC),
    .tc       (dwell_tc)
  );

  // Sweep FSM, stimulus registers and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      vec_idx   <= 2'd0;
      a         <= 1'b0;
      b         <= 1'b0;
      pass      <= 1'b0;
      err_count <= 3'd0;
      fail_vec  <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_DRIVE;
            vec_idx   <= 2'd0;
            a         <= 1'b0;
            b         <= 1'b0;
            pass      <= 1'b0;
            err_count <= 3'd0;
            fail_vec  <= 4'd0;
          end
        end
        S_DRIVE: begin
          if (dwell_tc) begin
            state <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          if (miss) begin
            if (err_count != ERR_MAX) begin
              err_count <= err_count + 3'd1;
            end
            fail_vec[{a, b}] <= 1'b1;
          end
          if (vec_idx == 2'd3) begin
            state <= S_FINISH;
            // Includes the sample taken in this same cycle.
            pass  <= (err_count == 3'd0) && !miss;
          end else begin
            state   <= S_DRIVE;
            vec_idx <= vec_next;
            a       <= vec_next[1];
            b       <= vec_next[0];
          end
        end
        default: begin
          state <= S_IDLE;
          a     <= 1'b0;
          b     <= 1'b0;
        end
      endcase
    end
  end

  // Status decoded from the state register.
  always_comb begin
    busy      = (state == S_DRIVE) || (state == S_SAMPLE);
    done      = (state == S_FINISH);
    state_dbg = state;
  end

endmodule

// File: tb/tb_gate_stim_checker.sv
// Directed-plus-random bench for gate_stim_checker. A truth-table driven gate
// model feeds y; expected per-cycle vectors and sweep results are computed
// from the sweep rules (vector = (cycle-1)/DWELL, mismatches = table XOR).
module tb_gate_stim_checker;
  import gate_tb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start;
  logic       sel;
  logic [3:0] tt;

  logic       a1, b1, y1, busy1, done1, pass1;
  logic [2:0] err1;
  logic [3:0] fv1;
  logic [1:0] st1;
  logic       a2, b2, y2, busy2, done2, pass2;
  logic [2:0] err2;
  logic [3:0] fv2;
  logic [1:0] st2;

  // Gate under test modelled by a truth table.
  assign y1 = tt[{a1, b1}];
  assign y2 = tt[{a2, b2}];

  gate_stim_checker #(.DWELL(10), .EXPECT_TT(XNOR_TT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start & ~sel), .y(y1),
    .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_vec(fv1), .state_dbg(st1)
  );

  gate_stim_checker #(.DWELL(2), .EXPECT_TT(XNOR_TT)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start & sel), .y(y2),
    .a(a2), .b(b2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .fail_vec(fv2), .state_dbg(st2)
  );

  logic       a_m, b_m, busy_m, done_m, pass_m;
  logic [2:0] err_m;
  logic [3:0] fv_m;
  assign a_m    = sel ? a2    : a1;
  assign b_m    = sel ? b2    : b1;
  assign busy_m = sel ? busy2 : busy1;
  assign done_m = sel ? done2 : done1;
  assign pass_m = sel ? pass2 : pass1;
  assign err_m  = sel ? err2  : err1;
  assign fv_m   = sel ? fv2   : fv1;

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic       last_pass;
  logic [2:0] last_err;
  logic [3:0] last_fv;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 8'(busy_m), 8'd0);
    chk({tag, "_done"}, 8'(done_m), 8'd0);
    chk({tag, "_a"}, 8'(a_m), 8'd0);
    chk({tag, "_b"}, 8'(b_m), 8'd0);
    chk({tag, "_pass"}, 8'(pass_m), 8'(last_pass));
    chk({tag, "_err"}, 8'(err_m), 8'(last_err));
    chk({tag, "_fv"}, 8'(fv_m), 8'(last_fv));
  endtask

  // ---------------- driver tasks ----------------
  // Full sweep with the gate table gtt; extra=1 adds stray start pulses at
  // cycle 5 (busy) and in the done cycle, both of which must be ignored.
  task automatic run_sweep(input int dw, input logic [3:0] gtt, input bit extra);
    logic [3:0] efv;
    int         ee;
    int         vi;
    tt  = gtt;
    efv = gtt ^ XNOR_TT;
    ee  = $countones(efv);
    chk_idle("pre_start");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 4 * dw + 1; k++) begin
      if (k == 1) begin
        chk("clr_err", 8'(err_m), 8'd0);
        chk("clr_fv", 8'(fv_m), 8'd0);
        chk("clr_pass", 8'(pass_m), 8'd0);
      end
      if (k <= 4 * dw) begin
        vi = (k - 1) / dw;
        chk("vec_a", 8'(a_m), 8'(vi[1]));
        chk("vec_b", 8'(b_m), 8'(vi[0]));
        chk("sweep_busy", 8'(busy_m), 8'd1);
        chk("sweep_done", 8'(done_m), 8'd0);
      end else begin
        chk("fin_done", 8'(done_m), 8'd1);
        chk("fin_busy", 8'(busy_m), 8'd0);
        chk("fin_pass", 8'(pass_m), 8'(ee == 0));
        chk("fin_err", 8'(err_m), 8'(ee));
        chk("fin_fv", 8'(fv_m), 8'(efv));
      end
      if (extra && (k == 5 || k == 4 * dw + 1)) start = 1'b1;
      else start = 1'b0;
      @(negedge clk);
    end
    start     = 1'b0;
    last_pass = (ee == 0);
    last_err  = 3'(ee);
    last_fv   = efv;
    for (int k = 0; k < 3; k++) begin
      chk_idle("post_done");
      @(negedge clk);
    end
  endtask

  task automatic idle_gap(input int n);
    for (int k = 0; k < n; k++) begin
      chk_idle("gap");
      @(negedge clk);
    end
  endtask

  task automatic clear_last();
    last_pass = 1'b0;
    last_err  = 3'd0;
    last_fv   = 4'd0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_last();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    sel   = 1'b0;
    tt    = XNOR_TT;
    clear_last();
    @(negedge clk);
    do_reset();
    chk_idle("reset");

    run_sweep(10, XNOR_TT, 1'b0);
    run_sweep(10, XOR_TT, 1'b0);
    run_sweep(10, 4'b1111, 1'b0);
    idle_gap(4);
    run_sweep(10, XNOR_TT, 1'b1);

    for (int r = 0; r < 3; r++) begin
      run_sweep(10, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      idle_gap($urandom_range(0, 5));
    end

    // Reset in the middle of vector 10: immediate abort, no done.
    run_sweep(10, XOR_TT, 1'b0);
    tt    = XNOR_TT;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k < 23; k++) @(negedge clk);
    chk("mid_a", 8'(a_m), 8'd1);
    chk("mid_b", 8'(b_m), 8'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    clear_last();
    chk_idle("abort");
    idle_gap(50);
    run_sweep(10, XNOR_TT, 1'b0);

    // start together with reset low is discarded.
    rst_n = 1'b0;
    start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    clear_last();
    chk_idle("rst_start");
    @(negedge clk);
    chk_idle("rst_start2");

    // Shortest dwell.
    do_reset();
    sel = 1'b1;
    chk_idle("reset2");
    run_sweep(2, XNOR_TT, 1'b0);
    run_sweep(2, AND_TT, 1'b1);
    run_sweep(2, 4'($urandom_range(0, 15)), 1'b0);
    run_sweep(2, XNOR_TT, 1'b0);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gate_stim_checker.md
GATE_STIM_CHECKER -- requirements
Module: gate_stim_checker

Interface
REQ-001 Parameter DWELL, default 10: clock cycles each input vector is held; legal range 2..255.
REQ-002 Parameter EXPECT_TT, default 4'b1001: expected 2-input truth table; bit index {a,b} gives expected y (XNOR).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  one-cycle pulse requesting a full sweep; ignored unless idle.
REQ-006 y  input  1  gate-under-test output.
REQ-007 a  output  1  gate input a, registered.
REQ-008 b  output  1  gate input b, registered.
REQ-009 busy  output  1  high from the cycle after accepted start until the cycle done asserts.
REQ-010 done  output  1  one-cycle pulse at sweep completion.
REQ-011 pass  output  1  valid while done=1 and held until next accepted start; 1 iff err_count==0.
REQ-012 err_count  output  3  number of mismatching vectors in the last sweep, 0..4.
REQ-013 fail_vec  output  4  bit {a,b} set if that vector mismatched in the last sweep.

Function
REQ-014 FSM states: IDLE, DRIVE, SAMPLE, FINISH; encoding from shared package.
REQ-015 IDLE: a=b=0, busy=0; start=1 -> DRIVE, vector index=0, dwell count=0, err_count=0, fail_vec=0, pass=0.
REQ-016 Vector order: {a,b} = 00, 01, 10, 11; a,b update on the cycle DRIVE is entered for each index.
REQ-017 DRIVE: dwell counter increments each cycle; at count DWELL-2 -> SAMPLE.
REQ-018 SAMPLE (single cycle, DWELL-th cycle of the vector): compare y with EXPECT_TT[{a,b}]; on mismatch increment err_count and set fail_vec[{a,b}].
REQ-019 SAMPLE with index<3 -> DRIVE with index+1, count=0; index==3 -> FINISH.
REQ-020 FINISH (single cycle): done=1, pass=(err_count==0 including the final sample), busy=0, then -> IDLE.
REQ-021 Each vector is held exactly DWELL cycles; sweep length start-to-done = 4*DWELL+1 cycles.
REQ-022 start while busy is ignored; start in the FINISH cycle is ignored.
REQ-023 err_count saturates at 4 and cannot wrap; fail_vec, err_count, pass hold their values in IDLE until the next accepted start.
REQ-024 Index counter is 2 bits and never wraps mid-sweep; dwell counter width is 8 bits.

Reset
REQ-025 rst_n=0 sampled on a rising edge forces IDLE, a=0, b=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0.
REQ-026 Reset mid-sweep aborts immediately with no done pulse; first accepted start afterwards begins a fresh sweep at vector 00.
REQ-027 start coincident with rst_n=0 is discarded.

Structure
REQ-028 Shared package gate_tb_pkg holds the FSM state enum, truth-table constants (AND_TT=4'b1000, OR_TT=4'b1110, XOR_TT=4'b0110, XNOR_TT=4'b1001, NAND_TT, NOR_TT) and the vector-count constant 4.
REQ-029 One sub-module, dwell_counter: 8-bit counter with clear and terminal-count flag, instantiated once.
REQ-030 Block connects directly to a 2-input gate instance; no combinational path from y to any output.

Verification
REQ-031 Correct XNOR gate, DWELL=10, start pulse -> a,b step 00,01,10,11 at 10-cycle intervals; done at cycle 41; pass=1, err_count=0, fail_vec=0000.
REQ-032 Gate replaced by XOR (all wrong) -> done at cycle 41, pass=0, err_count=4, fail_vec=1111.
REQ-033 Gate stuck-at-1 -> err_count=2, fail_vec=0110, pass=0.
REQ-034 rst_n low for one cycle during vector 10 -> a=b=0, busy=0, no done; new start -> full 41-cycle sweep, pass=1.
REQ-035 Second start pulses at cycles 5 and 41 of a sweep -> ignored, exactly one done; start in IDLE after done -> new sweep, previous results cleared on acceptance.
REQ-036 DWELL=2 with correct gate -> each vector held 2 cycles, done at cycle 9, pass=1.
